// File: rtl/huff_pkg.sv
// Shared definitions for the canonical Huffman table builder.
//   state_t      : controller states (IDLE, LOAD, BASE, CHECK, EMIT)
//   clog2        : ceiling log2 for elaboration-time sizing
//   kraft_width  : width of the Kraft accumulator; the length generator uses
//                  the same value so both sides agree on the sum format
//   bit_reverse  : reverses the low 'len' bits of a code (LSB-first writers)
package huff_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BASE,
    S_CHECK,
    S_EMIT
  } state_t;

  localparam int KRAFT_W_DEFAULT = 11 + 8 + 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // One term per symbol of up to 2^max_len each, over 2^sym_width symbols.
  function automatic int kraft_width(input int max_len, input int sym_width);
    return max_len + sym_width + 1;
  endfunction

  function automatic logic [14:0] bit_reverse(input logic [14:0] code,
                                              input logic [3:0]  len);
    logic [14:0] r;
    r = '0;
    for (int i = 0; i < 15; i++) begin
      if (i < int'(len)) r[int'(len) - 1 - i] = code[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/huff_canon_table_len_ram.sv
// Simple dual-port length RAM: one write port, one registered read port.
// Contents are not reset; every table rewrites the entries it uses.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : code length to store
//   rd_addr : read address, sampled every cycle
//   rd_data : registered read data (one cycle after rd_addr)
module huff_len_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/huff_canon_table.sv
// Canonical Huffman code-table builder.
// Loads one code length per symbol, builds per-length histograms, first
// codes and a Kraft sum, rejects illegal tables, then streams one
// {symbol, code, length} record per symbol in symbol order.
//   clk, rst                 : clock, synchronous active-high reset
//   len_valid_i/len_ready_o  : code-length input handshake
//   len_i, len_last_i        : length of next symbol (0 = unused), last flag
//   code_valid_o/code_ready_i: output record handshake
//   code_sym_o, code_o,
//   code_len_o, code_last_o  : output record (code right-aligned)
//   max_len_o, num_syms_o    : largest nonzero length, symbols loaded
//   err_o                    : one-cycle pulse when a table is rejected
//   busy_o                   : high outside IDLE
module huff_canon_table
  import huff_pkg::*;
#(
  parameter int SYM_WIDTH   = 8,
  parameter int MAX_LEN     = 11,
  parameter int LEN_WIDTH   = 4,
  parameter int BIT_REVERSE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 len_valid_i,
  output logic                 len_ready_o,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 len_last_i,
  output logic                 code_valid_o,
  input  logic                 code_ready_i,
  output logic [SYM_WIDTH-1:0] code_sym_o,
  output logic [MAX_LEN-1:0]   code_o,
  output logic [LEN_WIDTH-1:0] code_len_o,
  output logic                 code_last_o,
  output logic [LEN_WIDTH-1:0] max_len_o,
  output logic [SYM_WIDTH:0]   num_syms_o,
  output logic                 err_o,
  output logic                 busy_o
);

  localparam int NUM_SYMS = 1 << SYM_WIDTH;
  localparam int KW       = kraft_width(MAX_LEN, SYM_WIDTH);
  localparam int NCW      = MAX_LEN + 1;
  localparam int CW       = SYM_WIDTH + 1;
  localparam logic [CW-1:0]        LAST_SLOT  = CW'(NUM_SYMS - 1);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN_L  = LEN_WIDTH'(MAX_LEN);
  localparam logic [KW-1:0]        KRAFT_FULL = KW'(1) << MAX_LEN;

  state_t state, state_nxt;

  logic [CW-1:0]        sym_cnt;
  logic [LEN_WIDTH-1:0] max_len;
  logic                 bad_len;
  logic [LEN_WIDTH-1:0] base_l;
  logic [SYM_WIDTH-1:0] emit_sym;

  logic [CW-1:0]        bl_count  [0:MAX_LEN];
  logic [NCW-1:0]       next_code [0:MAX_LEN];
  logic [KW-1:0]        kraft;

  logic [SYM_WIDTH-1:0] wr_addr, rd_addr;
  logic [LEN_WIDTH-1:0] rd_len_p1;
  logic                 len_fire, len_over, slots_full, enter_base;
  logic                 emit_fire, emit_last, table_bad;
  logic [NCW-1:0]       prev_sum, code_raw;
  logic [KW-1:0]        kraft_term;
  logic [MAX_LEN-1:0]   code_fmt;

  assign len_ready_o = !rst && (state == S_IDLE || state == S_LOAD);
  assign len_fire    = len_valid_i && len_ready_o;
  assign len_over    = len_i > MAX_LEN_L;
  // The beat written into the final slot closes the table even without last.
  assign slots_full  = (state == S_LOAD) && (sym_cnt == LAST_SLOT);
  assign enter_base  = (state_nxt == S_BASE) && (state != S_BASE);
  assign emit_fire   = (state == S_EMIT) && code_ready_i;
  assign emit_last   = ({1'b0, emit_sym} == sym_cnt - 1'b1);
  assign table_bad   = bad_len || (kraft > KRAFT_FULL) || (max_len == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (len_fire) state_nxt = len_last_i ? S_BASE : S_LOAD;
      S_LOAD:  if (len_fire && (len_last_i || slots_full)) state_nxt = S_BASE;
      S_BASE:  if (base_l == MAX_LEN_L) state_nxt = S_CHECK;
      S_CHECK: state_nxt = table_bad ? S_IDLE : S_EMIT;
      S_EMIT:  if (emit_fire && emit_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt  <= '0;
      max_len  <= '0;
      bad_len  <= 1'b0;
      base_l   <= '0;
      emit_sym <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= (state == S_CHECK) && table_bad;
      if (len_fire) begin
        if (state == S_IDLE) begin
          sym_cnt <= CW'(1);
          max_len <= len_i;
          bad_len <= len_over;
        end else begin
          sym_cnt <= sym_cnt + 1'b1;
          if (len_i > max_len) max_len <= len_i;
          bad_len <= bad_len | len_over | (slots_full && !len_last_i);
        end
      end
      if (enter_base) base_l <= LEN_WIDTH'(1);
      else if (state == S_BASE && base_l != MAX_LEN_L) base_l <= base_l + 1'b1;
      if (state == S_CHECK) emit_sym <= '0;
      else if (emit_fire)   emit_sym <= emit_sym + 1'b1;
    end
  end

  // bl_count[0] never feeds next_code, so the l=1 step adds zero.
  always_comb begin
    prev_sum   = next_code[base_l - 1'b1] +
                 ((base_l == LEN_WIDTH'(1)) ? '0 : NCW'(bl_count[base_l - 1'b1]));
    kraft_term = KW'(bl_count[base_l]) << (MAX_LEN_L - base_l);
  end

  always_ff @(posedge clk) begin
    if (len_fire && state == S_IDLE) begin
      for (int i = 0; i <= MAX_LEN; i++)
        bl_count[i] <= (!len_over && len_i == LEN_WIDTH'(i)) ? CW'(1) : '0;
    end else if (len_fire && !len_over) begin
      bl_count[len_i] <= bl_count[len_i] + 1'b1;
    end
    if (enter_base) begin
      kraft        <= '0;
      next_code[0] <= '0;
    end
    if (state == S_BASE) begin
      next_code[base_l] <= prev_sum << 1;
      kraft             <= kraft + kraft_term;
    end
    if (emit_fire && rd_len_p1 != '0)
      next_code[rd_len_p1] <= next_code[rd_len_p1] + 1'b1;
  end

  // Read stage: address for the record shown next cycle. CHECK primes
  // symbol 0; EMIT advances on a handshake, else re-reads the held symbol.
  assign wr_addr = (state == S_IDLE) ? '0 : sym_cnt[SYM_WIDTH-1:0];
  assign rd_addr = (state != S_EMIT) ? '0 :
                   emit_fire ? emit_sym + 1'b1 : emit_sym;

  huff_len_ram #(
    .ADDR_W (SYM_WIDTH),
    .DATA_W (LEN_WIDTH)
  ) u_len_ram (
    .clk     (clk),
    .wr_en   (len_fire),
    .wr_addr (wr_addr),
    .wr_data (len_i),
    .rd_addr (rd_addr),
    .rd_data (rd_len_p1)
  );

  // Output stage: record formed combinationally from the registered length.
  always_comb begin
    code_raw = next_code[rd_len_p1];
    if (BIT_REVERSE != 0) code_fmt = MAX_LEN'(bit_reverse(15'(code_raw), 4'(rd_len_p1)));
    else                  code_fmt = MAX_LEN'(code_raw);
  end

  assign code_valid_o = (state == S_EMIT);
  assign code_sym_o   = code_valid_o ? emit_sym  : '0;
  assign code_len_o   = code_valid_o ? rd_len_p1 : '0;
  assign code_o       = code_valid_o ? code_fmt  : '0;
  assign code_last_o  = code_valid_o && emit_last;
  assign max_len_o    = max_len;
  assign num_syms_o   = sym_cnt;
  assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_huff_canon_table.sv
// Directed bench for huff_canon_table: an MSB-first and a bit-reversed
// instance share the same stimulus; records are compared against
// hand-computed tables and, for the 256-symbol case, a canonical-code model.
module tb_huff_canon_table;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, len_valid, len_last, code_ready;
  logic [3:0]  len;

  logic        lrdy, cv, clast, err, busy;
  logic [7:0]  csym;
  logic [10:0] code;
  logic [3:0]  clen, maxl;
  logic [8:0]  nsyms;

  logic        lrdy_r, cv_r, clast_r, err_r, busy_r;
  logic [7:0]  csym_r;
  logic [10:0] code_r;
  logic [3:0]  clen_r, maxl_r;
  logic [8:0]  nsyms_r;

  int tests = 0;
  int fails = 0;
  int lens     [256];
  int exp_code [256];
  int exp_rev  [256];

  huff_canon_table #(.SYM_WIDTH(8), .MAX_LEN(11), .LEN_WIDTH(4), .BIT_REVERSE(0)) dut (
    .clk(clk), .rst(rst), .len_valid_i(len_valid), .len_ready_o(lrdy),
    .len_i(len), .len_last_i(len_last), .code_valid_o(cv), .code_ready_i(code_ready),
    .code_sym_o(csym), .code_o(code), .code_len_o(clen), .code_last_o(clast),
    .max_len_o(maxl), .num_syms_o(nsyms), .err_o(err), .busy_o(busy));

  huff_canon_table #(.SYM_WIDTH(8), .MAX_LEN(11), .LEN_WIDTH(4), .BIT_REVERSE(1)) dut_r (
    .clk(clk), .rst(rst), .len_valid_i(len_valid), .len_ready_o(lrdy_r),
    .len_i(len), .len_last_i(len_last), .code_valid_o(cv_r), .code_ready_i(code_ready),
    .code_sym_o(csym_r), .code_o(code_r), .code_len_o(clen_r), .code_last_o(clast_r),
    .max_len_o(maxl_r), .num_syms_o(nsyms_r), .err_o(err_r), .busy_o(busy_r));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      len_valid = 1'b1;
      len       = 4'(lens[i]);
      len_last  = (i == n - 1);
      w = 0;
      while (!lrdy && w < 50) begin
        step();
        w++;
      end
      if (!lrdy) chk("send_ready", 32'(lrdy), 32'd1);
      step();
    end
    len_valid = 1'b0;
    len_last  = 1'b0;
    len       = 4'd0;
  endtask

  // Entered one cycle after the last length was accepted (t+1).
  task automatic expect_timing(input bit expect_err);
    repeat (11) step();
    chk("check_valid", 32'(cv), 32'd0);
    chk("check_err",   32'(err), 32'd0);
    chk("check_busy",  32'(busy), 32'd1);
    chk("check_lrdy",  32'(lrdy), 32'd0);
    step();
    chk("first_valid", 32'(cv),  32'(!expect_err));
    chk("err_pulse",   32'(err), 32'(expect_err));
    chk("err_pulse_r", 32'(err_r), 32'(expect_err));
    if (expect_err) begin
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_lrdy", 32'(lrdy), 32'd1);
      step();
      chk("err_one_cycle", 32'(err), 32'd0);
      chk("err_no_valid",  32'(cv),  32'd0);
    end
  endtask

  task automatic recv(input int n, input int emax, input bit rnd, input bit hold);
    int idx;
    int budget;
    idx = 0;
    budget = 0;
    while (idx < n && budget < 4000) begin
      code_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold) begin
        len_valid = 1'b1;
        len       = 4'd1;
        len_last  = 1'b1;
      end
      chk("valid",    32'(cv), 32'd1);
      chk("sym",      32'(csym), 32'(idx));
      chk("code",     32'(code), 32'(exp_code[idx]));
      chk("code_rev", 32'(code_r), 32'(exp_rev[idx]));
      chk("len",      32'(clen), 32'(lens[idx]));
      chk("last",     32'(clast), 32'(idx == n - 1));
      chk("max_len",  32'(maxl), 32'(emax));
      chk("num_syms", 32'(nsyms), 32'(n));
      chk("emit_lrdy", 32'(lrdy), 32'd0);
      if (cv && code_ready) idx++;
      step();
      budget++;
    end
    chk("recv_count", 32'(idx), 32'(n));
    chk("done_valid", 32'(cv), 32'd0);
    chk("done_busy",  32'(busy), 32'd0);
    chk("done_lrdy",  32'(lrdy), 32'd1);
    code_ready = 1'b0;
  endtask

  initial begin
    int bl [0:15];
    int nc [0:15];
    int c, emax, bad, s, r;

    rst = 1'b1; len_valid = 1'b0; len = 4'd0; len_last = 1'b0; code_ready = 1'b0;
    step();
    step();
    chk("rst_lrdy",  32'(lrdy), 32'd0);
    chk("rst_valid", 32'(cv), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_num",   32'(nsyms), 32'd0);
    chk("rst_max",   32'(maxl), 32'd0);
    chk("rst_last",  32'(clast), 32'd0);
    chk("rst_code",  32'(code), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_lrdy", 32'(lrdy), 32'd1);

    // {2,1,3,3}: 10, 0, 110, 111 ; reversed 01, 0, 011, 111
    lens[0] = 2; lens[1] = 1; lens[2] = 3; lens[3] = 3;
    exp_code[0] = 2; exp_code[1] = 0; exp_code[2] = 6; exp_code[3] = 7;
    exp_rev[0]  = 1; exp_rev[1]  = 0; exp_rev[2]  = 3; exp_rev[3]  = 7;
    send(4);
    expect_timing(1'b0);
    recv(4, 3, 1'b0, 1'b0);

    // {0,2,0,2,1}: 0/0, 10, 0/0, 11, 0 ; random stalls
    lens[0] = 0; lens[1] = 2; lens[2] = 0; lens[3] = 2; lens[4] = 1;
    exp_code[0] = 0; exp_code[1] = 2; exp_code[2] = 0; exp_code[3] = 3; exp_code[4] = 0;
    exp_rev[0]  = 0; exp_rev[1]  = 1; exp_rev[2]  = 0; exp_rev[3]  = 3; exp_rev[4]  = 0;
    send(5);
    expect_timing(1'b0);
    recv(5, 2, 1'b1, 1'b0);

    // Rejected tables: oversubscribed, over-long length, all zero.
    lens[0] = 1; lens[1] = 1; lens[2] = 1;
    send(3);
    expect_timing(1'b1);
    lens[0] = 12; lens[1] = 1;
    send(2);
    expect_timing(1'b1);
    lens[0] = 0; lens[1] = 0;
    send(2);
    expect_timing(1'b1);

    // 256 random legal lengths (8..11 or unused): Kraft sum <= 2^11.
    lens[0] = 8;
    for (int i = 1; i < 256; i++) begin
      r = int'($urandom_range(0, 4));
      lens[i] = (r == 0) ? 0 : 7 + r;
    end
    for (int l = 0; l < 16; l++) bl[l] = 0;
    emax = 0;
    for (int i = 0; i < 256; i++) begin
      if (lens[i] > 0) bl[lens[i]]++;
      if (lens[i] > emax) emax = lens[i];
    end
    c = 0;
    nc[0] = 0;
    for (int l = 1; l <= 11; l++) begin
      c = (c + ((l == 1) ? 0 : bl[l - 1])) << 1;
      nc[l] = c;
    end
    for (int i = 0; i < 256; i++) begin
      if (lens[i] == 0) begin
        exp_code[i] = 0;
        exp_rev[i]  = 0;
      end else begin
        exp_code[i] = nc[lens[i]];
        nc[lens[i]]++;
        exp_rev[i] = 0;
        for (int b = 0; b < lens[i]; b++)
          exp_rev[i] |= ((exp_code[i] >> b) & 1) << (lens[i] - 1 - b);
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++)
      for (int j = i + 1; j < 256; j++)
        if (lens[i] > 0 && lens[j] > 0) begin
          s = (lens[i] < lens[j]) ? lens[i] : lens[j];
          if ((exp_code[i] >> (lens[i] - s)) == (exp_code[j] >> (lens[j] - s))) bad++;
        end
    chk("prefix_free", 32'(bad), 32'd0);
    send(256);
    expect_timing(1'b0);
    recv(256, emax, 1'b1, 1'b0);

    // Reset in the middle of EMIT.
    lens[0] = 2; lens[1] = 1; lens[2] = 3; lens[3] = 3;
    exp_code[0] = 2; exp_code[1] = 0; exp_code[2] = 6; exp_code[3] = 7;
    send(4);
    expect_timing(1'b0);
    code_ready = 1'b1;
    chk("mid_sym0", 32'(csym), 32'd0);
    step();
    chk("mid_valid", 32'(cv), 32'd1);
    chk("mid_sym1",  32'(csym), 32'd1);
    chk("mid_code1", 32'(code), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_lrdy", 32'(lrdy), 32'd0);
    step();
    chk("mid_rst_valid", 32'(cv), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_num",   32'(nsyms), 32'd0);
    rst = 1'b0;
    code_ready = 1'b0;
    #1;
    chk("mid_rst_lrdy_after", 32'(lrdy), 32'd1);

    // {1,1} -> 0, 1 ; a length beat is held valid across the final handshake.
    lens[0] = 1; lens[1] = 1;
    exp_code[0] = 0; exp_code[1] = 1;
    exp_rev[0]  = 0; exp_rev[1]  = 1;
    send(2);
    expect_timing(1'b0);
    recv(2, 1, 1'b0, 1'b1);
    chk("beat_refused_num", 32'(nsyms), 32'd2);
    len_valid = 1'b0;
    len_last  = 1'b0;
    len       = 4'd0;
    step();
    chk("beat_refused_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
